// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARMv4-subset control FSM with NZCV flags and conditional-execution gating.
// Define MC_CTRL_BL_EN to add the LINK state so BL writes R14 before branching.
module arm_multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] instr_i,
   input  logic [3:0]  alu_flags_i,
   output logic        pc_write_o,
   output logic        adr_src_o,
   output logic        mem_write_o,
   output logic        ir_write_o,
   output logic [1:0]  result_src_o,
   output logic [1:0]  alu_control_o,
   output logic        alu_src_a_o,
   output logic [1:0]  alu_src_b_o,
   output logic [1:0]  imm_src_o,
   output logic        reg_write_o,
   output logic [1:0]  reg_src_o,
   output logic        link_sel_o
);
`ifdef MC_CTRL_BL_EN
   typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, LINK} state_e;
`else
   typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH} state_e;
`endif
   state_e     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_q, cond_ex;
   logic [3:0] cond, rd;
   logic [1:0] op, alu_dec;
   logic [5:0] funct;
   logic       n, z, c, v;
   logic       next_pc, ir_w, reg_w, mem_w, branch, link, pcs, upd;
   logic       unused_rn;
   assign cond      = instr_i[19:16];
   assign op        = instr_i[15:14];
   assign funct     = instr_i[13:8];
   assign rd        = instr_i[3:0];
   assign unused_rn = ^instr_i[7:4];
   assign {n, z, c, v} = flags_q;
   always_comb
      case (cond)
         4'h0:    cond_ex = z;
         4'h1:    cond_ex = ~z;
         4'h2:    cond_ex = c;
         4'h3:    cond_ex = ~c;
         4'h4:    cond_ex = n;
         4'h5:    cond_ex = ~n;
         4'h6:    cond_ex = v;
         4'h7:    cond_ex = ~v;
         4'h8:    cond_ex = c & ~z;
         4'h9:    cond_ex = ~c | z;
         4'hA:    cond_ex = n == v;
         4'hB:    cond_ex = n != v;
         4'hC:    cond_ex = ~z & (n == v);
         4'hD:    cond_ex = z | (n != v);
         4'hE:    cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   assign alu_dec = funct[4:1] == 4'b0010 ? 2'b01 :
                    funct[4:1] == 4'b0000 ? 2'b10 :
                    funct[4:1] == 4'b1100 ? 2'b11 : 2'b00;
   // C and V only move on arithmetic ops; logical ops leave them as they were
   assign upd     = (state_q == EXECR || state_q == EXECI) & funct[0] & cond_ex;
   assign flags_d = {upd ? alu_flags_i[3:2] : flags_q[3:2],
                     upd & ~alu_dec[1] ? alu_flags_i[1:0] : flags_q[1:0]};
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= FETCH;
         flags_q <= 4'h0;
         cond_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         cond_q  <= cond_ex;
      end
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE:
            case (op)
               2'b01:   state_d = MEMADR;
               2'b00:   state_d = funct[5] ? EXECI : EXECR;
`ifdef MC_CTRL_BL_EN
               2'b10:   state_d = funct[4] ? LINK : BRANCH;
`else
               2'b10:   state_d = BRANCH;
`endif
               default: state_d = FETCH;
            endcase
         MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         EXECR:  state_d = ALUWB;
         EXECI:  state_d = ALUWB;
`ifdef MC_CTRL_BL_EN
         LINK:   state_d = BRANCH;
`endif
         default: state_d = FETCH;
      endcase
   end
   always_comb begin
      next_pc       = 1'b0;
      ir_w          = 1'b0;
      reg_w         = 1'b0;
      mem_w         = 1'b0;
      branch        = 1'b0;
      link          = 1'b0;
      adr_src_o     = 1'b0;
      result_src_o  = 2'b00;
      alu_control_o = 2'b00;
      alu_src_a_o   = 1'b0;
      alu_src_b_o   = 2'b00;
      case (state_q)
         FETCH: begin
            next_pc      = 1'b1;
            ir_w         = 1'b1;
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
         end
         DECODE: begin
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
         end
         MEMADR: alu_src_b_o = 2'b01;
         MEMRD:  adr_src_o = 1'b1;
         MEMWB: begin
            result_src_o = 2'b01;
            reg_w        = 1'b1;
         end
         MEMWR: begin
            adr_src_o = 1'b1;
            mem_w     = 1'b1;
         end
         EXECR:  alu_control_o = alu_dec;
         EXECI: begin
            alu_src_b_o   = 2'b01;
            alu_control_o = alu_dec;
         end
         ALUWB:  reg_w = 1'b1;
         BRANCH: begin
            alu_src_b_o  = 2'b01;
            result_src_o = 2'b10;
            branch       = 1'b1;
         end
`ifdef MC_CTRL_BL_EN
         LINK: begin
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = 2'b11;
            result_src_o = 2'b10;
            reg_w        = 1'b1;
            link         = 1'b1;
         end
`endif
         default: ;
      endcase
   end
   // the LINK write targets R14, so its Rd field must not redirect the PC
   assign pcs         = branch | (reg_w & rd == 4'hF & ~link);
   assign pc_write_o  = ~reset & (next_pc | (pcs & cond_q));
   assign ir_write_o  = ~reset & ir_w;
   assign reg_write_o = ~reset & reg_w & cond_q;
   assign mem_write_o = ~reset & mem_w & cond_q;
   assign link_sel_o  = link;
   assign imm_src_o   = op;
   assign reg_src_o   = {op == 2'b01 & ~funct[0], op == 2'b10};
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: scoreboard bench; the stimulus pushes per-cycle expected control vectors,
// a negedge monitor pops and compares them against the live outputs.
module tb_arm_multicycle_ctrl;
   typedef enum {S_RST, S_F, S_D, S_MA, S_MR, S_MB, S_MW, S_ER, S_EI, S_AW, S_BR, S_LK} st_e;
   typedef struct {
      logic [16:0] v;
      string       n;
   } exp_t;
   logic        clk = 1'b0, reset = 1'b1;
   logic [19:0] instr = 20'h0;
   logic [3:0]  flags = 4'h0;
   logic        pc_write, adr_src, mem_write, ir_write, alu_src_a, reg_write, link_sel;
   logic [1:0]  result_src, alu_control, alu_src_b, imm_src, reg_src;
   logic [16:0] act;
   exp_t        sb[$];
   int          n_chk = 0, n_fail = 0, n_ins = 0, n_c = 0;
   logic [31:0] ins_c;
   logic [3:0]  fl_c;
   logic [1:0]  imm_e, rs_e;
   always #5 clk = ~clk;
   arm_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .instr_i(instr), .alu_flags_i(flags),
      .pc_write_o(pc_write), .adr_src_o(adr_src), .mem_write_o(mem_write), .ir_write_o(ir_write),
      .result_src_o(result_src), .alu_control_o(alu_control), .alu_src_a_o(alu_src_a),
      .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .reg_write_o(reg_write),
      .reg_src_o(reg_src), .link_sel_o(link_sel)
   );
   assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_control, alu_src_a,
                 alu_src_b, imm_src, reg_write, reg_src, link_sel};
   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_chk++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (pcw adr mw irw res alu sa sb imm rw rs lk)", e.n, act, e.v);
         end
      end
   task automatic begin_i(input logic [31:0] ins, input logic [3:0] fl, input logic [1:0] imm, input logic [1:0] rs);
      ins_c = ins;
      fl_c  = fl;
      imm_e = imm;
      rs_e  = rs;
      n_c   = 0;
      n_ins++;
   endtask
   task automatic s(input st_e st, input logic pcw, input logic wr, input logic [1:0] alu);
      exp_t       e;
      logic       adr = 1'b0, mw = 1'b0, irw = 1'b0, sa = 1'b0, rw = 1'b0, lk = 1'b0;
      logic [1:0] res = 2'b00, sbv = 2'b00;
      case (st)
         S_RST: begin res = 2'b10; sa = 1'b1; sbv = 2'b10; end
         S_F:   begin irw = 1'b1; res = 2'b10; sa = 1'b1; sbv = 2'b10; end
         S_D:   begin res = 2'b10; sa = 1'b1; sbv = 2'b10; end
         S_MA:  sbv = 2'b01;
         S_MR:  adr = 1'b1;
         S_MB:  begin res = 2'b01; rw = wr; end
         S_MW:  begin adr = 1'b1; mw = wr; end
         S_EI:  sbv = 2'b01;
         S_AW:  rw = wr;
         S_BR:  begin sbv = 2'b01; res = 2'b10; end
         S_LK:  begin sa = 1'b1; sbv = 2'b11; res = 2'b10; rw = wr; lk = 1'b1; end
         default: ;
      endcase
      e.v = {pcw, adr, mw, irw, res, alu, sa, sbv, imm_e, rw, rs_e, lk};
      e.n = $sformatf("%s_i%0d_%08h", st.name(), n_ins, ins_c);
      sb.push_back(e);
      n_c++;
   endtask
   task automatic go();
      instr = ins_c[31:12];
      flags = fl_c;
      repeat (n_c) @(posedge clk);
      #1;
   endtask
   task automatic br(input logic [31:0] ins, input logic taken);
      begin_i(ins, 4'h0, 2'b10, 2'b01);
      s(S_F, 1, 0, 2'b00); s(S_D, 0, 0, 2'b00); s(S_BR, taken, 0, 2'b00);
      go();
   endtask
   task automatic dp(input logic [31:0] ins, input logic [3:0] fl, input st_e ex, input logic [1:0] alu,
                     input logic pcw, input logic wr);
      begin_i(ins, fl, 2'b00, 2'b00);
      s(S_F, 1, 0, 2'b00); s(S_D, 0, 0, 2'b00); s(ex, 0, 0, alu); s(S_AW, pcw, wr, 2'b00);
      go();
   endtask
   task automatic mem(input logic [31:0] ins, input logic ld, input logic wr);
      begin_i(ins, 4'h0, 2'b01, ld ? 2'b00 : 2'b10);
      s(S_F, 1, 0, 2'b00); s(S_D, 0, 0, 2'b00); s(S_MA, 0, 0, 2'b00);
      if (ld) begin
         s(S_MR, 0, 0, 2'b00); s(S_MB, 0, wr, 2'b00);
      end else
         s(S_MW, 0, wr, 2'b00);
      go();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of program");
      $fatal(1, "watchdog");
   end
   initial begin
      @(posedge clk); #1;
      begin_i(32'h0, 4'h0, 2'b00, 2'b00);
      s(S_RST, 0, 0, 2'b00); s(S_RST, 0, 0, 2'b00);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mem(32'hE5903008, 1, 1);
      // abort an LDR in MEMRD: FETCH outputs with every write suppressed
      begin_i(32'hE5903008, 4'h0, 2'b01, 2'b00);
      s(S_F, 1, 0, 2'b00); s(S_D, 0, 0, 2'b00); s(S_MA, 0, 0, 2'b00);
      go();
      reset = 1'b1;
      s(S_RST, 0, 0, 2'b00);
      @(posedge clk);
      #1 reset = 1'b0;
      dp(32'hE2901005, 4'b0000, S_EI, 2'b00, 0, 1);
      dp(32'hE2512005, 4'b0110, S_EI, 2'b01, 0, 1);
      br(32'h1A000002, 0);
      br(32'h0A000002, 1);
      br(32'h3A000002, 0);
      br(32'h2A000002, 1);
      mem(32'h15803004, 0, 0);
      dp(32'h00911001, 4'b0000, S_ER, 2'b00, 0, 1);
      mem(32'h15803004, 0, 1);
      br(32'h0A000002, 0);
      dp(32'hE2512005, 4'b0010, S_EI, 2'b01, 0, 1);
      dp(32'hE2101001, 4'b0101, S_EI, 2'b10, 0, 1);
      br(32'h2A000002, 1);
      br(32'h6A000002, 0);
      br(32'h0A000002, 1);
      dp(32'h12801005, 4'b0000, S_EI, 2'b00, 0, 0);
      dp(32'hE1801002, 4'b1111, S_ER, 2'b11, 0, 1);
      br(32'h4A000002, 0);
      br(32'h6A000002, 0);
      dp(32'hE0201002, 4'b0000, S_ER, 2'b00, 0, 1);
      dp(32'hE280F004, 4'b0000, S_EI, 2'b00, 1, 1);
      begin_i(32'hEC000000, 4'h0, 2'b11, 2'b00);
      s(S_F, 1, 0, 2'b00); s(S_D, 0, 0, 2'b00);
      go();
      begin_i(32'hEB000001, 4'h0, 2'b10, 2'b01);
      s(S_F, 1, 0, 2'b00); s(S_D, 0, 0, 2'b00);
`ifdef MC_CTRL_BL_EN
      s(S_LK, 0, 1, 2'b00);
`endif
      s(S_BR, 1, 0, 2'b00);
      go();
      br(32'hEA000000, 1);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
